// File: rtl/l1_cache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate L1 cache between the LC-3b CPU port and
// physical memory. Hits answer combinationally; misses write back a dirty victim, then fill.
//   state     | meaning
//   CHECK     | look up request, answer hits, launch a miss
//   WRITEBACK | push dirty victim line to pmem
//   ALLOCATE  | fetch requested line from pmem
module l1_cache_direct_mapped #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TAG_BITS = 12 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e                state_q;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [INDEX_BITS-1:0] miss_idx_q;
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic [15:0]           pmem_address_q;
  logic [127:0]          pmem_wdata_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [2:0]            word_off;
  logic [6:0]            word_base;
  logic                  req_active;
  logic                  hit;
  logic                  wr_hit;
  logic [127:0]          line_d;
  logic                  unused_byte_bit;

  assign req_tag         = mem_address[15 -: TAG_BITS];
  assign req_idx         = mem_address[4 +: INDEX_BITS];
  assign word_off        = mem_address[3:1];
  assign word_base       = {word_off, 4'b0000};
  assign unused_byte_bit = mem_address[0];

  assign req_active = mem_read | mem_write;
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A request is answered only from CHECK, so mem_resp can never leak out of a miss sequence.
  assign mem_resp  = (state_q == CHECK) && req_active && hit;
  assign mem_rdata = mem_resp ? data_q[req_idx][word_base +: 16] : 16'h0000;
  assign wr_hit    = mem_resp && mem_write;

  always_comb begin
    line_d = data_q[req_idx];
    if (mem_byte_enable[0]) line_d[word_base +: 8]         = mem_wdata[7:0];
    if (mem_byte_enable[1]) line_d[word_base + 7'd8 +: 8]  = mem_wdata[15:8];
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Miss tag/index are latched so an in-flight transfer does not depend on the CPU holding its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= CHECK;
      valid_q        <= '0;
      dirty_q        <= '0;
      miss_tag_q     <= '0;
      miss_idx_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      case (state_q)
        CHECK: begin
          if (req_active && !hit) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q        <= WRITEBACK;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_q[req_idx], req_idx, 4'b0000};
              pmem_wdata_q   <= data_q[req_idx];
            end else begin
              state_q        <= ALLOCATE;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag, req_idx, 4'b0000};
            end
          end else if (wr_hit && (mem_byte_enable != 2'b00)) begin
            dirty_q[req_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state_q             <= ALLOCATE;
            dirty_q[miss_idx_q] <= 1'b0;
            pmem_write_q        <= 1'b0;
            pmem_wdata_q        <= '0;
            pmem_read_q         <= 1'b1;
            pmem_address_q      <= {miss_tag_q, miss_idx_q, 4'b0000};
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state_q             <= CHECK;
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
            pmem_read_q         <= 1'b0;
            pmem_address_q      <= '0;
          end
        end
        default: begin
          state_q        <= CHECK;
          pmem_read_q    <= 1'b0;
          pmem_write_q   <= 1'b0;
          pmem_address_q <= '0;
          pmem_wdata_q   <= '0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if ((state_q == ALLOCATE) && pmem_resp) begin
      data_q[miss_idx_q] <= pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (wr_hit) begin
      data_q[req_idx] <= line_d;
    end
  end

endmodule

// File: tb/tb_l1_cache_direct_mapped.sv
// Self-checking bench for l1_cache_direct_mapped: a flat-memory reference model predicts
// read data, writebacks, fills and latency for directed and randomized CPU traffic.
module tb_l1_cache_direct_mapped;

  logic         clk;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  l1_cache_direct_mapped #(.INDEX_BITS(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory behind the cache, and the CPU-visible memory the model predicts.
  logic [127:0] pmem_mem [4096];
  logic [15:0]  ref_mem  [32768];
  // Model of what the cache holds: which line sits at each index and whether it is newer than pmem.
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [8:0]   m_tag   [8];

  // Observed results of one access.
  logic [15:0]  r_rdata;
  int           r_cycles, r_wb, r_fill, r_order, r_viol;
  logic [15:0]  r_wb_addr, r_fill_addr;
  logic [127:0] r_wb_line;
  logic         r_tout;
  // Expected results of one access.
  logic [15:0]  e_rdata;
  int           e_cycles, e_wb, e_fill;
  logic [15:0]  e_wb_addr, e_fill_addr;
  logic [127:0] e_wb_line;

  task automatic sync_ref_from_pmem();
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        ref_mem[l*8 + w] = pmem_mem[l][w*16 +: 16];
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  task automatic model_access(input logic rd, input logic wr, input logic [1:0] be,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input int lw, input int lf);
    logic [2:0]  idx;
    logic [8:0]  tag;
    logic [15:0] word;
    idx = addr[6:4];
    tag = addr[15:7];
    e_wb = 0; e_fill = 0; e_cycles = 1; e_wb_addr = '0; e_fill_addr = '0; e_wb_line = '0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e_wb      = 1;
        e_wb_addr = {m_tag[idx], idx, 4'b0000};
        for (int w = 0; w < 8; w++) begin
          logic [2:0] wo;
          wo = w[2:0];
          e_wb_line[w*16 +: 16] = ref_mem[{m_tag[idx], idx, wo}];
        end
        e_cycles += lw + 1;
      end
      e_fill      = 1;
      e_fill_addr = {tag, idx, 4'b0000};
      e_cycles   += lf + 2;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    word = ref_mem[addr[15:1]];
    e_rdata = word;
    if (wr) begin
      if (be[0]) word[7:0]  = wd[7:0];
      if (be[1]) word[15:8] = wd[15:8];
      ref_mem[addr[15:1]] = word;
      if (be != 2'b00) m_dirty[idx] = 1'b1;
    end
    rd = rd;
  endtask

  // Drives one CPU request and plays the pmem side with the given response latencies.
  task automatic cpu_access(input logic rd, input logic wr, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wd,
                            input int lw, input int lf);
    int wcnt, fcnt;
    wcnt = 0; fcnt = 0;
    r_rdata = '0; r_cycles = 0; r_wb = 0; r_fill = 0; r_order = 0; r_viol = 0;
    r_wb_addr = '0; r_fill_addr = '0; r_wb_line = '0; r_tout = 1'b1;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = addr; mem_wdata = wd;
    pmem_resp = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      #1;
      if (pmem_read && pmem_write) r_viol++;
      if (mem_resp) begin
        if (pmem_read || pmem_write) r_viol++;
        r_rdata  = mem_rdata;
        r_cycles = c;
        r_tout   = 1'b0;
        break;
      end
      if (pmem_write) begin
        if (wcnt == lw) begin
          pmem_resp = 1'b1;
          r_wb++;
          r_wb_addr = pmem_address;
          r_wb_line = pmem_wdata;
          pmem_mem[pmem_address[15:4]] = pmem_wdata;
          if (r_order == 0) r_order = 1;
        end else wcnt++;
      end else if (pmem_read) begin
        if (pmem_wdata !== 128'h0) r_viol++;
        if (fcnt == lf) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_mem[pmem_address[15:4]];
          r_fill++;
          r_fill_addr = pmem_address;
          if (r_order == 0) r_order = 2;
        end else fcnt++;
      end else if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
        r_viol++;
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd, input int lw, input int lf);
    model_access(rd, wr, be, addr, wd, lw, lf);
    cpu_access(rd, wr, be, addr, wd, lw, lf);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0; mem_wdata = 16'h0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got resp/rd/wr=%b expected 000", {mem_resp, pmem_read, pmem_write});
    end
    checks++;
    if (mem_rdata !== 16'h0 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h paddr=%h pwdata=%h expected all 0", mem_rdata, pmem_address, pmem_wdata);
    end
    mem_read = 1'b1; mem_address = 16'h1234;
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_req: resp=%b pmem_read=%b expected 0 0", mem_resp, pmem_read);
    end
    mem_read = 1'b0; mem_address = 16'h0;
    reset = 1'b0;
    sync_ref_from_pmem();
    @(negedge clk);
  endtask

  task automatic test_plan_sequence();
    access(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 2);
    checks++;
    if (r_fill !== 1 || r_fill_addr !== 16'h1230 || r_wb !== 0) begin
      errors++;
      $display("FAIL first_fill: fills=%0d addr=%h wbs=%0d expected 1 1230 0", r_fill, r_fill_addr, r_wb);
    end
    checks++;
    if (r_tout || r_rdata !== 16'h0002 || r_cycles !== 5) begin
      errors++;
      $display("FAIL first_read: tout=%b rdata=%h cycles=%0d expected 0 0002 5", r_tout, r_rdata, r_cycles);
    end
    access(1'b1, 1'b0, 2'b11, 16'h1236, 16'h0, 0, 0);
    checks++;
    if (r_rdata !== 16'h0003 || r_cycles !== 1 || r_fill !== 0) begin
      errors++;
      $display("FAIL read_hit: rdata=%h cycles=%0d fills=%0d expected 0003 1 0", r_rdata, r_cycles, r_fill);
    end
    access(1'b0, 1'b1, 2'b01, 16'h1234, 16'hABCD, 0, 0);
    checks++;
    if (r_cycles !== 1 || r_fill !== 0) begin
      errors++;
      $display("FAIL write_hit: cycles=%0d fills=%0d expected 1 0", r_cycles, r_fill);
    end
    access(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 0);
    checks++;
    if (r_rdata !== 16'h00CD) begin
      errors++;
      $display("FAIL byte_merge: rdata=%h expected 00cd", r_rdata);
    end
    access(1'b1, 1'b0, 2'b11, 16'h5234, 16'h0, 1, 0);
    checks++;
    if (r_order !== 1 || r_wb !== 1 || r_wb_addr !== 16'h1230 || r_wb_line[47:32] !== 16'h00CD) begin
      errors++;
      $display("FAIL dirty_evict: order=%0d wbs=%0d addr=%h word2=%h expected 1 1 1230 00cd",
               r_order, r_wb, r_wb_addr, r_wb_line[47:32]);
    end
    checks++;
    if (r_fill_addr !== 16'h5230 || r_rdata !== e_rdata || r_cycles !== e_cycles) begin
      errors++;
      $display("FAIL evict_fill: addr=%h rdata=%h cycles=%0d expected 5230 %h %0d",
               r_fill_addr, r_rdata, r_cycles, e_rdata, e_cycles);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic saw;
    saw = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (pmem_read) begin
        saw = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!saw) begin
      errors++;
      $display("FAIL reset_fill_start: pmem_read never rose, got 0 expected 1");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_address !== 16'h0 || mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pmem_read=%b paddr=%h resp=%b expected 0 0000 0", pmem_read, pmem_address, mem_resp);
    end
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0; mem_address = 16'h0;
    sync_ref_from_pmem();
    access(1'b1, 1'b0, 2'b11, 16'h5234, 16'h0, 0, 1);
    checks++;
    if (r_fill !== 1 || r_rdata !== e_rdata || r_tout) begin
      errors++;
      $display("FAIL reset_invalidates: fills=%0d rdata=%h tout=%b expected 1 %h 0", r_fill, r_rdata, r_tout, e_rdata);
    end
  endtask

  task automatic test_byte_enable_zero();
    access(1'b0, 1'b1, 2'b00, 16'h5236, 16'hBEEF, 0, 0);
    checks++;
    if (r_cycles !== 1) begin
      errors++;
      $display("FAIL be00_resp: cycles=%0d expected 1", r_cycles);
    end
    access(1'b1, 1'b0, 2'b11, 16'h5236, 16'h0, 0, 0);
    checks++;
    if (r_rdata !== e_rdata) begin
      errors++;
      $display("FAIL be00_data: rdata=%h expected %h", r_rdata, e_rdata);
    end
    access(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 0);
    checks++;
    if (r_wb !== 0 || r_fill !== 1) begin
      errors++;
      $display("FAIL be00_clean: wbs=%0d fills=%0d expected 0 1", r_wb, r_fill);
    end
  endtask

  task automatic test_read_write_both();
    access(1'b1, 1'b0, 2'b11, 16'h5230, 16'h0, 0, 0);
    access(1'b1, 1'b1, 2'b11, 16'h5230, 16'h1111, 0, 0);
    checks++;
    if (r_cycles !== 1 || r_tout) begin
      errors++;
      $display("FAIL both_resp: cycles=%0d tout=%b expected 1 0", r_cycles, r_tout);
    end
    access(1'b1, 1'b0, 2'b11, 16'h5230, 16'h0, 0, 0);
    checks++;
    if (r_rdata !== 16'h1111) begin
      errors++;
      $display("FAIL both_write: rdata=%h expected 1111", r_rdata);
    end
    access(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0, 2, 1);
    checks++;
    if (r_wb !== 1 || r_wb_addr !== 16'h5230 || r_wb_line[15:0] !== 16'h1111) begin
      errors++;
      $display("FAIL both_dirty: wbs=%0d addr=%h word0=%h expected 1 5230 1111", r_wb, r_wb_addr, r_wb_line[15:0]);
    end
  endtask

  task automatic test_index_boundary();
    logic [2:0]  idx;
    logic [15:0] a1, a2, wd;
    for (int k = 0; k < 2; k++) begin
      idx = (k == 0) ? 3'd0 : 3'd7;
      a1  = {9'h0A5, idx, 4'h6};
      a2  = {9'h13C, idx, 4'hA};
      wd  = 16'($urandom);
      access(1'b1, 1'b0, 2'b11, a1, 16'h0, 0, 0);
      access(1'b0, 1'b1, 2'b11, a1, wd, 0, 0);
      access(1'b1, 1'b0, 2'b11, a2, 16'h0, 0, 1);
      checks++;
      if (r_wb !== e_wb || r_wb_addr !== e_wb_addr || r_wb_line !== e_wb_line) begin
        errors++;
        $display("FAIL edge_idx%0d_wb: wbs=%0d addr=%h expected %0d %h", idx, r_wb, r_wb_addr, e_wb, e_wb_addr);
      end
      access(1'b1, 1'b0, 2'b11, a1, 16'h0, 1, 0);
      checks++;
      if (r_rdata !== wd || r_fill !== 1) begin
        errors++;
        $display("FAIL edge_idx%0d_read: rdata=%h fills=%0d expected %h 1", idx, r_rdata, r_fill, wd);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0]  tags [4];
    logic [15:0] addr, wd;
    logic        rd, wr;
    logic [1:0]  be;
    int          kind, lw, lf;
    tags[0] = 9'h012; tags[1] = 9'h0A5; tags[2] = 9'h1FF; tags[3] = 9'h000;
    for (int n = 0; n < 150; n++) begin
      addr = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      wd   = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      lw   = $urandom_range(0, 3);
      lf   = $urandom_range(0, 3);
      access(rd, wr, be, addr, wd, lw, lf);
      checks++;
      if (r_tout || r_viol != 0 || r_cycles != e_cycles) begin
        errors++;
        $display("FAIL rand%0d_timing: tout=%b viol=%0d cycles=%0d expected 0 0 %0d", n, r_tout, r_viol, r_cycles, e_cycles);
      end
      checks++;
      if (r_wb != e_wb || r_fill != e_fill) begin
        errors++;
        $display("FAIL rand%0d_xfers: wbs=%0d fills=%0d expected %0d %0d", n, r_wb, r_fill, e_wb, e_fill);
      end
      if (e_wb == 1) begin
        checks++;
        if (r_wb_addr !== e_wb_addr || r_wb_line !== e_wb_line || r_order != 1) begin
          errors++;
          $display("FAIL rand%0d_wb: addr=%h order=%0d line=%h expected %h 1 %h", n, r_wb_addr, r_order, r_wb_line, e_wb_addr, e_wb_line);
        end
      end
      if (e_fill == 1) begin
        checks++;
        if (r_fill_addr !== e_fill_addr) begin
          errors++;
          $display("FAIL rand%0d_fill: addr=%h expected %h", n, r_fill_addr, e_fill_addr);
        end
      end
      if (!wr) begin
        checks++;
        if (r_rdata !== e_rdata) begin
          errors++;
          $display("FAIL rand%0d_rdata: addr=%h rdata=%h expected %h", n, addr, r_rdata, e_rdata);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r0, r1, r2, r3;
    for (int l = 0; l < 4096; l++) begin
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      pmem_mem[l] = {r3, r2, r1, r0};
    end
    for (int w = 0; w < 8; w++) pmem_mem[12'h123][w*16 +: 16] = 16'(w);
    test_reset();
    test_plan_sequence();
    test_reset_mid_fill();
    test_byte_enable_zero();
    test_read_write_both();
    test_index_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
